// File: rtl/spi_transmitter_32bit.sv
// SPI mode-0 master that sends one 32-bit word per frame, MSB first.
// Words arrive on a valid/ready handshake, and a one-cycle done pulse marks the end of each frame.
module spi_transmitter_32bit #(
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        i_RESET_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_SPI_CLK,
    output logic        o_SPI_CS_n,
    output logic        o_SPI_MOSI
);

    localparam int HW   = $clog2(CLK_DIV);
    localparam int MAXD = (CS_SETUP > CS_HOLD)
                        ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                        : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int DW   = $clog2(MAXD + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state, state_nx;
    logic [HW-1:0]   phase_cnt, phase_cnt_nx;
    logic [4:0]      bit_cnt, bit_cnt_nx;
    logic [DW-1:0]   dly_cnt, dly_cnt_nx;
    logic [31:0]     shreg, shreg_nx;
    logic            ready_nx, busy_nx, done_nx, sck_nx, cs_n_nx, mosi_nx;

    always_ff @(posedge clk) begin
        if (!i_RESET_n) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            dly_cnt    <= '0;
            shreg      <= '0;
            o_ready    <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_SPI_CLK  <= 1'b0;
            o_SPI_CS_n <= 1'b1;
            o_SPI_MOSI <= 1'b0;
        end else begin
            state      <= state_nx;
            phase_cnt  <= phase_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            dly_cnt    <= dly_cnt_nx;
            shreg      <= shreg_nx;
            o_ready    <= ready_nx;
            o_busy     <= busy_nx;
            o_done     <= done_nx;
            o_SPI_CLK  <= sck_nx;
            o_SPI_CS_n <= cs_n_nx;
            o_SPI_MOSI <= mosi_nx;
        end
    end

    // Next values of every register are computed here so all outputs stay registered.
    always_comb begin
        state_nx     = state;
        phase_cnt_nx = phase_cnt;
        bit_cnt_nx   = bit_cnt;
        dly_cnt_nx   = dly_cnt;
        shreg_nx     = shreg;
        ready_nx     = o_ready;
        busy_nx      = o_busy;
        done_nx      = 1'b0;
        sck_nx       = o_SPI_CLK;
        cs_n_nx      = o_SPI_CS_n;
        mosi_nx      = o_SPI_MOSI;

        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    shreg_nx   = i_data;
                    mosi_nx    = i_data[31];
                    cs_n_nx    = 1'b0;
                    ready_nx   = 1'b0;
                    busy_nx    = 1'b1;
                    dly_cnt_nx = '0;
                    state_nx   = SETUP;
                end
            end
            SETUP: begin
                if (dly_cnt == DW'(CS_SETUP - 1)) begin
                    dly_cnt_nx   = '0;
                    phase_cnt_nx = '0;
                    bit_cnt_nx   = 5'd31;
                    state_nx     = SHIFT;
                end else begin
                    dly_cnt_nx = dly_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (phase_cnt == HW'(CLK_DIV - 1)) begin
                    phase_cnt_nx = '0;
                    if (!o_SPI_CLK) begin
                        sck_nx = 1'b1;
                    end else begin
                        // Falling edge: advance MOSI, or finish after the last bit.
                        sck_nx = 1'b0;
                        if (bit_cnt == 5'd0) begin
                            mosi_nx    = 1'b0;
                            dly_cnt_nx = '0;
                            state_nx   = HOLD;
                        end else begin
                            bit_cnt_nx = bit_cnt - 5'd1;
                            shreg_nx   = shreg << 1;
                            mosi_nx    = shreg[30];
                        end
                    end
                end else begin
                    phase_cnt_nx = phase_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (dly_cnt == DW'(CS_HOLD - 1)) begin
                    dly_cnt_nx = '0;
                    cs_n_nx    = 1'b1;
                    done_nx    = 1'b1;
                    state_nx   = GAP;
                end else begin
                    dly_cnt_nx = dly_cnt + 1'b1;
                end
            end
            GAP: begin
                if (dly_cnt == DW'(CS_GAP - 1)) begin
                    dly_cnt_nx = '0;
                    ready_nx   = 1'b1;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    dly_cnt_nx = dly_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
                busy_nx  = 1'b0;
                sck_nx   = 1'b0;
                cs_n_nx  = 1'b1;
                mosi_nx  = 1'b0;
            end
        endcase
    end

endmodule
